// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- handshaked sequential ALU.
//
// Single-cycle operations (logic, add/sub, compares, shifts) complete on the
// acceptance edge. Multi-cycle operations run iteratively, one step per clock:
//   MUL/MULHU  radix-2 shift-add
//   DIVU/REMU  restoring division
// The result and zero flag are registered and held while the consumer stalls.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, alu_control captured on accept)
//   out_valid/out_ready  result handshake (result, zero)
//   busy                 high while an iterative operation is in progress
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_op;
    logic [WIDTH-1:0]     r_a;       // MUL: multiplicand; DIV: dividend, shifting into quotient
    logic [WIDTH-1:0]     r_b;       // MUL: multiplier, shifting into low product; DIV: divisor
    logic [WIDTH-1:0]     r_acc;     // MUL: high product; DIV: partial remainder
    logic [SHAMT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;

    logic                 w_accept;
    logic                 w_is_multi;
    logic                 w_is_mul_op;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]     w_single;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH-1:0]     w_mul_hi;
    logic [WIDTH-1:0]     w_mul_lo;
    logic [WIDTH:0]       w_div_shift;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_diff;
    logic [WIDTH-1:0]     w_div_q;
    logic [WIDTH-1:0]     w_div_rem;
    logic [WIDTH-1:0]     w_calc_res;

    assign in_ready    = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_is_multi  = alu_control inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
    assign w_is_mul_op = (r_op == OP_MUL) || (r_op == OP_MULHU);
    assign w_shamt     = b[SHAMT_W-1:0];

    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_CALC);
    assign result    = r_result;
    assign zero      = r_zero;

    // Single-cycle datapath, evaluated directly on the live inputs.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        w_single = '0;
        case (alu_control)
            OP_AND:  w_single = a & b;
            OP_OR:   w_single = a | b;
            OP_ADD:  w_single = a + b;
            OP_XOR:  w_single = a ^ b;
            OP_SLL:  w_single = a << w_shamt;
            OP_SRL:  w_single = a >> w_shamt;
            OP_SUB:  w_single = a - b;
            OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SRA:  w_single = $signed(a) >>> w_shamt;
            OP_SLTU: w_single = {{(WIDTH-1){1'b0}}, (a < b)};
            default: w_single = '0;   // reserved and multi-cycle codes
        endcase
    end

    // Shift-add step: add the multiplicand when the current multiplier LSB is
    // set, then shift the {hi, lo} product right by one. The multiplier is
    // consumed from r_b while low product bits fill it from the top.
    assign w_mul_sum = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_b[WIDTH-1:1]};

    // Restoring division step. The compare uses the full WIDTH+1 bits so a
    // zero divisor always "fits": the quotient becomes all ones and the
    // remainder ends as the dividend, with no special casing.
    assign w_div_shift = {r_acc, r_a[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;
    assign w_div_q     = {r_a[WIDTH-2:0], w_div_ge};
    assign w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];

    always_comb begin
        w_calc_res = w_div_rem;
        case (r_op)
            OP_MUL:   w_calc_res = w_mul_lo;
            OP_MULHU: w_calc_res = w_mul_hi;
            OP_DIVU:  w_calc_res = w_div_q;
            default:  w_calc_res = w_div_rem;
        endcase
    end

    // FSM state register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_is_multi ? S_CALC : S_DONE;
            S_CALC: if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE: begin
                if (w_accept)       w_state_next = w_is_multi ? S_CALC : S_DONE;
                else if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else if (w_accept) begin
            r_op  <= alu_control;
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= SHAMT_W'(WIDTH - 1);
            // A multi-cycle accept leaves the old result in place; it is not
            // visible because out_valid is low until the new one is written.
            if (!w_is_multi) begin
                r_result <= w_single;
                r_zero   <= (w_single == '0);
            end
        end else if (r_state == S_CALC) begin
            if (w_is_mul_op) begin
                r_acc <= w_mul_hi;
                r_b   <= w_mul_lo;
            end else begin
                r_acc <= w_div_rem;
                r_a   <= w_div_q;
            end
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_result <= w_calc_res;
                r_zero   <= (w_calc_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq (WIDTH = 32).
// Inputs are driven on the falling edge or 1 ns after the rising edge; outputs
// are sampled 1 ns after the rising edge or on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   alu_control = 4'b0000;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Issue one operation with out_ready=1 and wait (bounded) for out_valid.
    // cyc counts rising edges from the acceptance edge (inclusive) until
    // out_valid is seen; bcnt counts samples with busy high in between.
    // Inputs are scrambled right after acceptance to prove they were captured.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int cyc, output int bcnt);
        @(negedge clk);
        alu_control = op; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~av; b = ~bv; alu_control = 4'b0010;
        cyc = 1; bcnt = 0;
        while (!out_valid && cyc < 200) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout op=%b: out_valid=%b after %0d cycles, required 1", op, out_valid, cyc);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (result !== 32'h0)   begin errors++; $display("FAIL reset_result: got %h want 00000000", result); end
        checks++; if (zero !== 1'b1)      begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_arith();
        int cyc, bc;
        run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, cyc, bc);
        checks++; if (cyc !== 1)               begin errors++; $display("FAIL add_latency: got %0d want 1", cyc); end
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL add_result: got %h want 80000000", result); end
        checks++; if (zero !== 1'b0)           begin errors++; $display("FAIL add_zero: got %b want 0", zero); end
        run_op(4'b0110, 32'd5, 32'd5, cyc, bc);
        checks++; if (result !== 32'h0)        begin errors++; $display("FAIL sub_result: got %h want 00000000", result); end
        checks++; if (zero !== 1'b1)           begin errors++; $display("FAIL sub_zero: got %b want 1", zero); end
    endtask

    task automatic test_compare_shift();
        int cyc, bc;
        run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, cyc, bc);
        checks++; if (result !== 32'h1) begin errors++; $display("FAIL slt: got %h want 00000001", result); end
        run_op(4'b1001, 32'hFFFF_FFFF, 32'h1, cyc, bc);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL sltu: got %h want 00000000", result); end
        run_op(4'b1000, 32'h8000_0000, 32'h0000_0024, cyc, bc);
        checks++; if (result !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h want f8000000", result); end
        run_op(4'b0100, 32'h1, 32'd31, cyc, bc);
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL sll: got %h want 80000000", result); end
        run_op(4'b0101, 32'h8000_0000, 32'hFFFF_FFE1, cyc, bc);
        checks++; if (result !== 32'h4000_0000) begin errors++; $display("FAIL srl: got %h want 40000000", result); end
        run_op(4'b0001, 32'h0000_F000, 32'h0000_000F, cyc, bc);
        checks++; if (result !== 32'h0000_F00F) begin errors++; $display("FAIL or: got %h want 0000f00f", result); end
        run_op(4'b1110, 32'h1234_5678, 32'h1, cyc, bc);
        checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL reserved: got %h/%b want 00000000/1", result, zero); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        alu_control = 4'b0001; a = 32'h0F; b = 32'hF0; in_valid = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || result !== 32'hFF) begin errors++; $display("FAIL b2b_or: got %b/%h want 1/000000ff", out_valid, result); end
        alu_control = 4'b0110; a = 32'd3; b = 32'd5;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_sub: got %b/%h want 1/fffffffe", out_valid, result); end
        alu_control = 4'b0010; a = 32'hFFFF_FFFF; b = 32'h1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL b2b_add: got %b/%h/%b want 1/00000000/1", out_valid, result, zero); end
        in_valid = 1'b0;
    endtask

    task automatic test_multicycle();
        int cyc, bc;
        run_op(4'b1010, 32'h0001_0000, 32'h0001_0001, cyc, bc);
        checks++; if (cyc !== 33)               begin errors++; $display("FAIL mul_latency: got %0d want 33", cyc); end
        checks++; if (bc !== 32)                begin errors++; $display("FAIL mul_busy_cycles: got %0d want 32", bc); end
        checks++; if (result !== 32'h0001_0000) begin errors++; $display("FAIL mul: got %h want 00010000", result); end
        run_op(4'b1011, 32'h0001_0000, 32'h0001_0001, cyc, bc);
        checks++; if (result !== 32'h1)         begin errors++; $display("FAIL mulhu: got %h want 00000001", result); end
        run_op(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bc);
        checks++; if (result !== 32'h1)         begin errors++; $display("FAIL mul_max: got %h want 00000001", result); end
        run_op(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bc);
        checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_max: got %h want fffffffe", result); end
        run_op(4'b1100, 32'd100, 32'd7, cyc, bc);
        checks++; if (result !== 32'd14)        begin errors++; $display("FAIL divu: got %h want 0000000e", result); end
        run_op(4'b1101, 32'd100, 32'd7, cyc, bc);
        checks++; if (result !== 32'd2)         begin errors++; $display("FAIL remu: got %h want 00000002", result); end
        run_op(4'b1100, 32'd9, 32'd0, cyc, bc);
        checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by_zero: got %h want ffffffff", result); end
        run_op(4'b1101, 32'd9, 32'd0, cyc, bc);
        checks++; if (result !== 32'd9 || zero !== 1'b0) begin errors++; $display("FAIL remu_by_zero: got %h/%b want 00000009/0", result, zero); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        alu_control = 4'b0011; a = 32'h0000_F0F0; b = 32'h0000_0FF0; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        // A competing request held during the stall must be ignored.
        alu_control = 4'b0010; a = 32'h1; b = 32'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== 32'h0000_FF00 || zero !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: valid/result/zero/in_ready=%b/%h/%b/%b want 1/0000ff00/0/0",
                         i, out_valid, result, zero, in_ready);
            end
        end
        out_ready = 1'b1;
        alu_control = 4'b0000; a = 32'hFF00_FF00; b = 32'h0F0F_0F0F;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'h0F00_0F00) begin errors++; $display("FAIL release_and: got %b/%h want 1/0f000f00", out_valid, result); end
    endtask

    task automatic test_reset_mid_calc();
        int cyc, bc, pulses;
        @(negedge clk);
        alu_control = 4'b1100; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divu_started: busy=%b want 1", busy); end
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || zero !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: valid/busy/result/zero/in_ready=%b/%b/%h/%b/%b want 0/0/00000000/1/1",
                     out_valid, busy, result, zero, in_ready);
        end
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || busy) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL discarded_op: %0d active samples want 0", pulses); end
        run_op(4'b0010, 32'd2, 32'd3, cyc, bc);
        checks++; if (result !== 32'd5 || cyc !== 1) begin errors++; $display("FAIL add_after_reset: got %h in %0d want 00000005 in 1", result, cyc); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_compare_shift();
        test_back_to_back();
        test_multicycle();
        test_backpressure();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
